// File: rtl/exp_result_bcd.sv
// rtl/exp_result_bcd.sv - 32-bit binary to 10-digit packed BCD converter (double dabble) for the display path
module exp_result_bcd (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] bin,
    output logic        ready,
    output logic        valid,
    output logic [39:0] bcd,
    output logic [3:0]  ndigits,
    output logic [7:0]  hex_digits
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t      state;
    logic [31:0] shift_reg;
    logic [39:0] scratch;
    logic [5:0]  cycle_cnt;

    logic [39:0] scratch_adj;
    logic [39:0] scratch_next;
    logic [3:0]  ndigits_next;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary MSB
    always_comb begin
        scratch_adj = scratch;
        for (int i = 0; i < 10; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        scratch_next = {scratch_adj[38:0], shift_reg[31]};
    end

    // Significant digit count of the step result; a value of zero still shows one digit
    always_comb begin
        ndigits_next = 4'd1;
        for (int i = 0; i < 10; i++) begin
            if (scratch_next[4*i +: 4] != 4'd0) begin
                ndigits_next = 4'(i + 1);
            end
        end
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            ready      <= 1'b1;
            valid      <= 1'b0;
            bcd        <= 40'd0;
            ndigits    <= 4'd1;
            hex_digits <= 8'd0;
            cycle_cnt  <= 6'd0;
            scratch    <= 40'd0;
            shift_reg  <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        shift_reg <= bin;
                        scratch   <= 40'd0;
                        cycle_cnt <= 6'd32;
                        ready     <= 1'b0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= {shift_reg[30:0], 1'b0};
                    scratch   <= scratch_next;
                    cycle_cnt <= cycle_cnt - 6'd1;
                    // The 32nd shift publishes the finished digits
                    if (cycle_cnt == 6'd1) begin
                        bcd        <= scratch_next;
                        ndigits    <= ndigits_next;
                        hex_digits <= scratch_next[7:0];
                        valid      <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/exp_result_bcd.md
EXP_RESULT_BCD -- requirements
Module: exp_result_bcd

Purpose: downstream stage of the exponent engine; converts the 32-bit result p to packed BCD for the LEDR/HEX display path; same ready/enable microprotocol.

Interface
REQ-001 Parameters: none; all widths fixed as below.
REQ-002 clock  in  1  single clock; all state changes on posedge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 enable  in  1  start request; sampled only while ready=1.
REQ-005 bin  in  32  unsigned binary value to convert (engine result p).
REQ-006 ready  out  1  high = idle, request accepted on next posedge.
REQ-007 valid  out  1  one-cycle pulse: bcd/ndigits/hex_digits hold a new result.
REQ-008 bcd  out  40  10 packed BCD digits; digit i at bits [4i+3:4i], i=0 least significant.
REQ-009 ndigits  out  4  count of significant decimal digits, 1..10.
REQ-010 hex_digits  out  8  equals bcd[7:0] (two least-significant digits for exp_hex).

Function
REQ-011 States: IDLE, SHIFT, DONE; exactly one active.
REQ-012 IDLE: ready=1; on posedge with enable=1 -> capture bin into 32-bit shift register, clear 40-bit BCD scratch, load 6-bit cycle counter with 32, go to SHIFT, ready=0.
REQ-013 IDLE with enable=0: remain IDLE; all outputs hold.
REQ-014 SHIFT: each posedge, every scratch digit >=5 gets +3, then {scratch, shiftreg} shifts left by 1 (double dabble); counter decrements.
REQ-015 SHIFT: the posedge performing the 32nd shift also loads bcd, ndigits, hex_digits from final scratch and moves to DONE.
REQ-016 DONE: valid=1, ready=0 for exactly one cycle; next posedge -> IDLE, valid=0, ready=1.
REQ-017 Latency: enable accepted at edge E0; outputs update and valid rises at E32; ready rises at E33; next request accepted no earlier than E34.
REQ-018 enable while in SHIFT or DONE: ignored; no restart, no queuing; bin changes after E0 have no effect.
REQ-019 bcd, ndigits, hex_digits change only at entry to DONE or on reset; otherwise hold the last result.
REQ-020 ndigits = 1 + index of the most-significant nonzero digit; bin=0 -> ndigits=1.
REQ-021 Every bcd digit is 0..9 for any 32-bit input; max input 4294967295 fits in 10 digits; no overflow flag.
REQ-022 valid never asserts without a preceding accepted enable.

Reset
REQ-023 reset=1 forces immediately (asynchronously) state=IDLE, ready=1, valid=0, bcd=0, ndigits=1, hex_digits=0, counter=0, scratch=0.
REQ-024 reset asserted mid-SHIFT or in DONE aborts the conversion; no valid pulse for it; after release, an enable converts normally.
REQ-025 enable high during reset is ignored; first acceptance is the first posedge with reset=0.

Verification
REQ-026 bin=0, enable one cycle -> valid at E32, bcd=0, ndigits=1, hex_digits=8'h00, ready=1 at E33.
REQ-027 bin=32'hFFFFFFFF -> bcd=40'h4294967295, ndigits=10, hex_digits=8'h95.
REQ-028 bin=1000 then, after ready, bin=59 -> bcd=40'h0000001000/ndigits=4, then bcd=40'h0000000059/ndigits=2, hex_digits=8'h59; exactly two valid pulses.
REQ-029 bin=12345, enable held high continuously -> conversions every 34 cycles, each bcd=40'h0000012345; bin changed to 7 mid-SHIFT does not affect current result.
REQ-030 bin=999, reset pulsed at E10 -> outputs return to reset values immediately, no valid; subsequent bin=7 conversion gives bcd=7, ndigits=1.
REQ-031 Random bench: 1000 random 32-bit inputs vs. software decimal reference; every digit <=9, ndigits correct, valid exactly once per request.
